// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 word RAM slave: registered-feedback ACK/ERR one cycle after req, then one beat per cycle; never stalls.
// Incrementing/wrapping CTI/BTE bursts exist only when WB_SLAVE_BURST_EN is defined; otherwise every beat is classic.
module wb_burst_ram_slave #(
  parameter int Dw     = 32,
  parameter int Aw     = 32,
  parameter int SELw   = 4,
  parameter int TAGw   = 3,
  parameter int CTIw   = 3,
  parameter int BTEw   = 2,
  parameter int RAM_Aw = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   s_adr_i,
  input  logic [Dw-1:0]   s_dat_i,
  input  logic [SELw-1:0] s_sel_i,
  input  logic [TAGw-1:0] s_tag_i,
  input  logic            s_we_i,
  input  logic            s_cyc_i,
  input  logic            s_stb_i,
  input  logic [CTIw-1:0] s_cti_i,
  input  logic [BTEw-1:0] s_bte_i,
  output logic [Dw-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic            s_err_o,
  output logic            s_rty_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [Dw-1:0]     mem [2**RAM_Aw];
  logic [0:0]        state_q, state_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic [RAM_Aw-1:0] baddr_q, baddr_d, baddr_nxt, widx, rd_addr;
  logic [Dw-1:0]     dat_q;
  logic              req, illegal, burst_go, rd_en, wr_en;
  logic              unused_ok;

  assign req     = s_cyc_i & s_stb_i;
  assign illegal = (s_sel_i == '0) || (s_adr_i[1:0] != 2'b00);
  assign widx    = s_adr_i[RAM_Aw+1:2];

`ifdef WB_SLAVE_BURST_EN
  logic [RAM_Aw-1:0] wrap_mask, baddr_inc;

  // Wrapping bursts only advance the low bits selected by the mask.
  always_comb begin
    case (s_bte_i[1:0])
      2'b01:   wrap_mask = RAM_Aw'(3);
      2'b10:   wrap_mask = RAM_Aw'(7);
      2'b11:   wrap_mask = RAM_Aw'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign baddr_inc = baddr_q + RAM_Aw'(1);
  assign baddr_nxt = (baddr_q & ~wrap_mask) | (baddr_inc & wrap_mask);
  assign burst_go  = req && (s_cti_i == CTIw'(3'b010));
  assign unused_ok = ^{s_tag_i, s_adr_i[Aw-1:RAM_Aw+2]};
`else
  assign baddr_nxt = baddr_q;
  assign burst_go  = 1'b0;
  assign unused_ok = ^{s_tag_i, s_adr_i[Aw-1:RAM_Aw+2], s_cti_i, s_bte_i};
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    baddr_d = baddr_q;
    rd_en   = 1'b0;
    rd_addr = widx;
    case (state_q)
      IDLE: begin
        if (req && !ack_q && !err_q) begin
          state_d = ACTIVE;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            ack_d   = 1'b1;
            baddr_d = widx;
            rd_en   = 1'b1;
          end
        end
      end
      default: begin
        // An ack cycle implies the first beat was legal.
        if (ack_q && burst_go) begin
          ack_d   = 1'b1;
          baddr_d = baddr_nxt;
          rd_en   = 1'b1;
          rd_addr = baddr_nxt;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign wr_en = (state_q == ACTIVE) && ack_q && req && s_we_i;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SELw; b++) begin
        if (s_sel_i[b]) mem[baddr_q][8*b +: 8] <= s_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      baddr_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      baddr_q <= baddr_d;
      if (rd_en) dat_q <= mem[rd_addr];
    end
  end

  assign s_dat_o = dat_q;
  assign s_ack_o = ack_q;
  assign s_err_o = err_q;
  assign s_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed bench for wb_burst_ram_slave; burst expectations follow WB_SLAVE_BURST_EN.
module tb_wb_burst_ram_slave;

`ifdef WB_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic [2:0]  tag;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  int n_tests = 0;
  int n_fail  = 0;

  wb_burst_ram_slave dut (
    .clk     (clk),
    .reset   (reset),
    .s_adr_i (adr),
    .s_dat_i (dat_i),
    .s_sel_i (sel),
    .s_tag_i (tag),
    .s_we_i  (we),
    .s_cyc_i (cyc),
    .s_stb_i (stb),
    .s_cti_i (cti),
    .s_bte_i (bte),
    .s_dat_o (dat_o),
    .s_ack_o (ack),
    .s_err_o (err),
    .s_rty_o (rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'h0;
  endtask

  // One classic access held for exactly two edges; reports first-cycle ack/err/data and any termination in the second.
  task automatic wb_single(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic a1, output logic e1, output logic [31:0] r1, output logic term2);
    adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; cti = 3'b000; bte = 2'b00;
    tick;
    a1 = ack; e1 = err; r1 = dat_o;
    tick;
    term2 = ack | err;
    bus_idle;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_idle;
    adr = '0; dat_i = '0; tag = 3'b101;
    tick; tick;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++; if (rty !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b expected 0", rty); end
    n_tests++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 00000000", dat_o); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_classic;
    logic a1, e1, t2;
    logic [31:0] r1;
    wb_single(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a1, e1, r1, t2);
    n_tests++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL classic_wr_ack: got %b expected 1", a1); end
    n_tests++; if (e1 !== 1'b0) begin n_fail++; $display("FAIL classic_wr_err: got %b expected 0", e1); end
    n_tests++; if (t2 !== 1'b0) begin n_fail++; $display("FAIL classic_wr_pulse: got %b expected 0", t2); end
    wb_single(1'b0, 32'h10, 32'h0, 4'hF, a1, e1, r1, t2);
    n_tests++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL classic_rd_ack: got %b expected 1", a1); end
    n_tests++; if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL classic_rd_dat: got %h expected deadbeef", r1); end
  endtask

  task automatic test_byte_sel;
    logic a1, e1, t2;
    logic [31:0] r1;
    wb_single(1'b1, 32'h20, 32'h00000000, 4'hF, a1, e1, r1, t2);
    wb_single(1'b1, 32'h20, 32'h11223344, 4'b0010, a1, e1, r1, t2);
    n_tests++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL bytesel_wr_ack: got %b expected 1", a1); end
    wb_single(1'b0, 32'h20, 32'h0, 4'hF, a1, e1, r1, t2);
    n_tests++; if (r1 !== 32'h00003300) begin n_fail++; $display("FAIL bytesel_rd_dat: got %h expected 00003300", r1); end
  endtask

  task automatic test_back_to_back;
    adr = 32'h10; sel = 4'hF; we = 1'b0; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_tests++;
      if (ack !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, ack, ((k % 2) == 0));
      end
    end
    n_tests++; if (dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_dat: got %h expected deadbeef", dat_o); end
    bus_idle;
    tick;
  endtask

  task automatic test_linear_burst;
    logic a1, e1, t2;
    logic [31:0] r1;
    logic [31:0] exp_d;
    for (int k = 0; k < 4; k++) wb_single(1'b1, 32'h40 + 32'(4*k), 32'hFFFFFFFF, 4'hF, a1, e1, r1, t2);
    adr = 32'h40; dat_i = 32'h10; sel = 4'hF; we = 1'b1; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      dat_i = 32'h10 + 32'(k);
      cti = (k == 3) ? 3'b111 : 3'b010;
      n_tests++;
      if (ack !== (BURST || (k % 2) == 0)) begin
        n_fail++; $display("FAIL lin_ack[%0d]: got %b expected %b", k, ack, (BURST || (k % 2) == 0));
      end
      tick;
    end
    n_tests++; if (ack !== !BURST) begin n_fail++; $display("FAIL lin_end_ack: got %b expected %b", ack, !BURST); end
    bus_idle;
    tick;
    for (int k = 0; k < 4; k++) begin
      wb_single(1'b0, 32'h40 + 32'(4*k), 32'h0, 4'hF, a1, e1, r1, t2);
      exp_d = BURST ? (32'h10 + 32'(k)) : ((k == 0) ? 32'h12 : 32'hFFFFFFFF);
      n_tests++; if (r1 !== exp_d) begin n_fail++; $display("FAIL lin_rd[%0d]: got %h expected %h", k, r1, exp_d); end
    end
  endtask

  task automatic test_wrap4;
    logic a1, e1, t2;
    logic [31:0] r1;
    logic [31:0] exp_d;
    logic [3:0]  beat_w [4];
    beat_w[0] = 4'hE; beat_w[1] = 4'hF; beat_w[2] = 4'hC; beat_w[3] = 4'hD;
    for (int k = 12; k < 16; k++) wb_single(1'b1, 32'(4*k), 32'hC0DE0000 + 32'(k), 4'hF, a1, e1, r1, t2);
    adr = 32'h38; sel = 4'hF; we = 1'b0; cti = 3'b010; bte = 2'b01; cyc = 1'b1; stb = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      cti = (k == 3) ? 3'b111 : 3'b010;
      exp_d = 32'hC0DE0000 + (BURST ? 32'(beat_w[k]) : 32'hE);
      n_tests++;
      if (ack !== (BURST || (k % 2) == 0)) begin
        n_fail++; $display("FAIL wrap_ack[%0d]: got %b expected %b", k, ack, (BURST || (k % 2) == 0));
      end
      n_tests++; if (dat_o !== exp_d) begin n_fail++; $display("FAIL wrap_dat[%0d]: got %h expected %h", k, dat_o, exp_d); end
      tick;
    end
    n_tests++; if (ack !== !BURST) begin n_fail++; $display("FAIL wrap_end_ack: got %b expected %b", ack, !BURST); end
    bus_idle;
    tick;
  endtask

  task automatic test_error;
    logic a1, e1, t2;
    logic [31:0] r1;
    logic [31:0] exp_d;
    wb_single(1'b0, 32'h10, 32'h0, 4'hF, a1, e1, r1, t2);
    wb_single(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, a1, e1, r1, t2);
    n_tests++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL err_sel_err: got %b expected 1", e1); end
    n_tests++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL err_sel_ack: got %b expected 0", a1); end
    n_tests++; if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_sel_dathold: got %h expected deadbeef", r1); end
    n_tests++; if (t2 !== 1'b0) begin n_fail++; $display("FAIL err_sel_pulse: got %b expected 0", t2); end
    wb_single(1'b1, 32'h41, 32'h00000000, 4'hF, a1, e1, r1, t2);
    n_tests++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL err_adr_err: got %b expected 1", e1); end
    n_tests++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL err_adr_ack: got %b expected 0", a1); end
    wb_single(1'b0, 32'h10, 32'h0, 4'hF, a1, e1, r1, t2);
    n_tests++; if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_sel_ram: got %h expected deadbeef", r1); end
    wb_single(1'b0, 32'h40, 32'h0, 4'hF, a1, e1, r1, t2);
    exp_d = BURST ? 32'h10 : 32'h12;
    n_tests++; if (r1 !== exp_d) begin n_fail++; $display("FAIL err_adr_ram: got %h expected %h", r1, exp_d); end
  endtask

  task automatic test_reset_mid_burst;
    logic a1, e1, t2;
    logic [31:0] r1;
    wb_single(1'b1, 32'h80, 32'h0, 4'hF, a1, e1, r1, t2);
    wb_single(1'b1, 32'h84, 32'h0, 4'hF, a1, e1, r1, t2);
    adr = 32'h80; dat_i = 32'hA0; sel = 4'hF; we = 1'b1; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    tick;
    tick;
    dat_i = 32'hA1;
    n_tests++; if (ack !== BURST) begin n_fail++; $display("FAIL rst_pre_ack: got %b expected %b", ack, BURST); end
    reset = 1'b1;
    #1;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_async_ack: got %b expected 0", ack); end
    n_tests++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_async_dat: got %h expected 00000000", dat_o); end
    tick;
    reset = 1'b0;
    bus_idle;
    tick;
    wb_single(1'b0, 32'h80, 32'h0, 4'hF, a1, e1, r1, t2);
    n_tests++; if (r1 !== 32'hA0) begin n_fail++; $display("FAIL rst_beat1: got %h expected 000000a0", r1); end
    wb_single(1'b0, 32'h84, 32'h0, 4'hF, a1, e1, r1, t2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL rst_beat2: got %h expected 00000000", r1); end
  endtask

  initial begin
    test_reset;
    test_classic;
    test_byte_sel;
    test_back_to_back;
    test_linear_burst;
    test_wrap4;
    test_error;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_ram_slave.md
# wb_burst_ram_slave

Wishbone B3 slave endpoint: a word-organised single-port RAM that answers transactions driven onto one slave port of the team's parametrizable Wishbone bus. It provides registered-feedback responses for classic cycles and for incrementing/wrapping bursts signalled by CTI/BTE. It also detects illegal accesses and answers them with ERR. It is the responder-side counterpart of the bus's master-to-slave broadcast path.

## Interface
- Dw, 32, data width; must be a multiple of 8.
- Aw, 32, bus byte-address width.
- SELw, 4, byte selects; equals Dw/8.
- TAGw, 3, tag width; input accepted and ignored.
- CTIw, 3, cycle type width.
- BTEw, 2, burst type width.
- RAM_Aw, 8, word-address width; depth is 2^RAM_Aw words.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- s_adr_i  input  Aw  byte address; word index is s_adr_i[RAM_Aw+1:2].
- s_dat_i  input  Dw  write data.
- s_sel_i  input  SELw  byte enables.
- s_tag_i  input  TAGw  unused.
- s_we_i  input  1  write enable.
- s_cyc_i  input  1  cycle valid.
- s_stb_i  input  1  strobe; the bus already gates it with the slave select.
- s_cti_i  input  CTIw  000 classic, 010 incrementing burst, 111 end of burst.
- s_bte_i  input  BTEw  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- s_dat_o  output  Dw  read data.
- s_ack_o  output  1  normal termination.
- s_err_o  output  1  error termination.
- s_rty_o  output  1  retry; constant 0.

## Operation
- Request: `req = s_cyc_i & s_stb_i`.
- Illegal access: `s_sel_i == 0` or `s_adr_i[1:0] != 0`.
- FSM states:
  - IDLE to ACTIVE, when req is high and neither ack nor err is high. On that edge:
    - Legal access: `ack <= 1`, `baddr <= word index`, `s_dat_o <= mem[word index]`.
    - Illegal access: `err <= 1`, `s_dat_o` holds its value.
  - ACTIVE, ack high: if req and we, write `mem[baddr]` byte-wise under `s_sel_i` at the edge.
    - Burst continues when req is high, `s_cti_i == 010`, and the first beat was legal. Then ack stays 1, `baddr <= next(baddr)`, `s_dat_o <= mem[next(baddr)]`.
    - Otherwise ack goes to 0 and the FSM returns to IDLE. This covers cti 000, cti 111, a dropped req, and a dropped cyc.
  - ACTIVE, err high: err goes to 0 and the FSM returns to IDLE; no write is performed.
- `next(baddr)` by BTE:
  - linear: +1 modulo 2^RAM_Aw.
  - wrap4 / wrap8 / wrap16: increment the low 2 / 3 / 4 bits; upper bits unchanged.
- Beats after the first take their address from `baddr` only; `s_adr_i` is ignored. Legality is checked on the first beat only.
- ack and err are never high together.
- Reset:
  - ack = 0, err = 0, rty = 0, `s_dat_o = 0`, FSM = IDLE, `baddr = 0`.
  - RAM contents are undefined and not cleared.
  - Reset asserted mid-burst clears ack immediately (asynchronously); no write happens at a later edge.

## Timing
- Classic access: 2 cycles per transfer. req is seen at edge E, ack is high in the cycle after E, and a write commits at edge E+1.
- Back-to-back classic accesses from a master that holds stb: ack pulses every other cycle.
- Burst of N beats: N+1 cycles. The first ack comes one cycle after req; then one ack per cycle.
- Read data is valid in every ack cycle and comes from a registered synchronous RAM read.
- Wait states: if the master drops stb during a burst, the burst ends. A later req restarts as a classic first beat using `s_adr_i`.

## Configuration
- `WB_SLAVE_BURST_EN`:
  - Defined: burst behaviour as specified above.
  - Undefined: `s_cti_i` and `s_bte_i` are ignored. Every beat terminates like cti 000, giving a single-cycle ack pulse, 2 cycles per transfer, and no `baddr` increment logic.

## Test plan
- Classic write then read:
  - Write 0xDEADBEEF to address 0x10 with sel 1111. Requires one ack pulse one cycle after stb, and err = 0.
  - Read 0x10. Requires `s_dat_o` = 0xDEADBEEF in the ack cycle.
- Byte select: write 0x11223344 to 0x20 with sel 0010, after 0x00000000 was written there. A read of 0x20 returns 0x00003300.
- Linear burst: write 4 beats at 0x40 (cti 010, 010, 010, 111; bte 00).
  - Requires 4 consecutive ack cycles after a one-cycle latency.
  - Read-back returns words 0x10..0x13 in order.
- Wrap4 burst:
  - Read burst starting at word 0x0E with bte 01 and 4 beats. Beat addresses must be 0x0E, 0x0F, 0x0C, 0x0D.
  - With `WB_SLAVE_BURST_EN` undefined, the same stimulus yields only classic pulses.
- Error: sel = 0000, or address 0x41, gives err for one cycle, ack = 0, and RAM unchanged.
- Reset mid-burst: assert reset during the 2nd beat of a write burst.
  - ack drops at once and `s_dat_o` becomes 0.
  - Only beat 1 is committed.
